// File: rtl/splash_if.sv
// Splash painter bus: mode strobes and ROM data in, framebuffer write port and ROM address out.
interface splash_if;
    logic        showTitle;
    logic        drawBlack;
    logic        showGameOver;
    logic        flash;
    logic        wren;
    logic [2:0]  title_pix;
    logic [2:0]  gameover_pix;
    logic [14:0] rom_addr;
    logic [7:0]  x;
    logic [6:0]  y;
    logic [2:0]  colour;
    logic        plot;
    logic        frame_done;

    // Splash FSM and ROMs side
    modport master (
        output showTitle, drawBlack, showGameOver, flash, wren, title_pix, gameover_pix,
        input  rom_addr, x, y, colour, plot, frame_done
    );

    // Painter side
    modport slave (
        input  showTitle, drawBlack, showGameOver, flash, wren, title_pix, gameover_pix,
        output rom_addr, x, y, colour, plot, frame_done
    );
endinterface

// File: rtl/splash_painter.sv
// Splash painter: rasters a WIDTH x HEIGHT frame and writes title, game-over,
// black or flash pixels into the framebuffer through a fixed 2-cycle pipeline.
module splash_painter #(
    parameter int unsigned WIDTH        = 160,
    parameter int unsigned HEIGHT       = 120,
    parameter logic [2:0]  FLASH_COLOUR = 3'b100
) (
    input  logic    clk,
    input  logic    rst,
    splash_if.slave bus
);
    localparam int unsigned XW = 8;
    localparam int unsigned YW = 7;
    localparam int unsigned AW = 15;
    localparam int unsigned CW = 3;

    typedef enum logic [2:0] {
        MODE_NONE     = 3'd0,
        MODE_TITLE    = 3'd1,
        MODE_GAMEOVER = 3'd2,
        MODE_FLASH    = 3'd3,
        MODE_BLACK    = 3'd4
    } mode_e;

    mode_e          mode_c;
    logic           at_row_end_c;
    logic           at_last_c;

    // Raster counters (stage 0)
    logic [XW-1:0]  x_cnt_q, x_cnt_d;
    logic [YW-1:0]  y_cnt_q, y_cnt_d;

    // Stage-1 pixel payload, aligned with the ROM read
    logic           valid1_q, valid1_d;
    mode_e          mode1_q, mode1_d;
    logic [XW-1:0]  x1_q, x1_d;
    logic [YW-1:0]  y1_q, y1_d;
    logic           last1_q, last1_d;

    // Stage-2 framebuffer write registers
    logic [XW-1:0]  x_q, x_d;
    logic [YW-1:0]  y_q, y_d;
    logic [CW-1:0]  colour_q, colour_d;
    logic           plot_q, plot_d;
    logic           frame_done_q, frame_done_d;

    // Mode priority at issue: black > flash > game-over > title > none
    always_comb begin
        mode_c = MODE_NONE;
        if (bus.drawBlack)         mode_c = MODE_BLACK;
        else if (bus.flash)        mode_c = MODE_FLASH;
        else if (bus.showGameOver) mode_c = MODE_GAMEOVER;
        else if (bus.showTitle)    mode_c = MODE_TITLE;
    end

    // Raster advance; dropping wren rewinds to (0,0) so every burst starts a fresh frame
    always_comb begin
        x_cnt_d      = x_cnt_q;
        y_cnt_d      = y_cnt_q;
        at_row_end_c = (x_cnt_q == XW'(WIDTH - 1));
        at_last_c    = at_row_end_c && (y_cnt_q == YW'(HEIGHT - 1));
        if (!bus.wren) begin
            x_cnt_d = '0;
            y_cnt_d = '0;
        end else if (at_row_end_c) begin
            x_cnt_d = '0;
            y_cnt_d = at_last_c ? '0 : y_cnt_q + YW'(1);
        end else begin
            x_cnt_d = x_cnt_q + XW'(1);
        end
    end

    // Issue: capture pixel context while the ROM registers the address
    always_comb begin
        valid1_d = bus.wren;
        mode1_d  = mode_c;
        x1_d     = x_cnt_q;
        y1_d     = y_cnt_q;
        last1_d  = at_last_c;
    end

    // Output stage: colour select and write strobes
    always_comb begin
        plot_d       = valid1_q && (mode1_q != MODE_NONE);
        frame_done_d = valid1_q && (mode1_q != MODE_NONE) && last1_q;
        x_d          = x1_q;
        y_d          = y1_q;
        case (mode1_q)
            MODE_BLACK:    colour_d = CW'(0);
            MODE_FLASH:    colour_d = FLASH_COLOUR;
            MODE_GAMEOVER: colour_d = bus.gameover_pix;
            MODE_TITLE:    colour_d = bus.title_pix;
            default:       colour_d = CW'(0);
        endcase
    end

    // State registers; reset aborts any in-flight pixels
    always_ff @(posedge clk) begin
        if (rst) begin
            x_cnt_q      <= '0;
            y_cnt_q      <= '0;
            valid1_q     <= 1'b0;
            mode1_q      <= MODE_NONE;
            x1_q         <= '0;
            y1_q         <= '0;
            last1_q      <= 1'b0;
            x_q          <= '0;
            y_q          <= '0;
            colour_q     <= '0;
            plot_q       <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            x_cnt_q      <= x_cnt_d;
            y_cnt_q      <= y_cnt_d;
            valid1_q     <= valid1_d;
            mode1_q      <= mode1_d;
            x1_q         <= x1_d;
            y1_q         <= y1_d;
            last1_q      <= last1_d;
            x_q          <= x_d;
            y_q          <= y_d;
            colour_q     <= colour_d;
            plot_q       <= plot_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign bus.rom_addr   = AW'(y_cnt_q) * AW'(WIDTH) + AW'(x_cnt_q);
    assign bus.x          = x_q;
    assign bus.y          = y_q;
    assign bus.colour     = colour_q;
    assign bus.plot       = plot_q;
    assign bus.frame_done = frame_done_q;
endmodule

// File: tb/tb_splash_painter.sv
// Directed bench for splash_painter: mode priority table plus frame-level sequences.
module tb_splash_painter;
    localparam int W    = 160;
    localparam int H    = 120;
    localparam int NPIX = W * H;

    localparam int K_BLACK = 0;
    localparam int K_FLASH = 1;
    localparam int K_GO    = 2;
    localparam int K_TITLE = 3;

    logic clk = 1'b0;
    logic rst;

    splash_if bus();

    splash_painter #(.WIDTH(W), .HEIGHT(H), .FLASH_COLOUR(3'b100)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Synchronous ROM models: title = addr[2:0], game-over = ~addr[2:0]
    always @(posedge clk) begin
        bus.title_pix    <= bus.rom_addr[2:0];
        bus.gameover_pix <= ~bus.rom_addr[2:0];
    end

    int checks = 0;
    int errors = 0;
    int gx[NPIX];
    int gy[NPIX];
    int gc[NPIX];

    typedef struct {
        bit       black;
        bit       flsh;
        bit       go;
        bit       title;
        bit       exp_plot;
        int       exp_col;
    } vec_t;

    vec_t vecs[9];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic set_mode(input bit b, input bit f, input bit g, input bit t);
        bus.drawBlack    = b;
        bus.flash        = f;
        bus.showGameOver = g;
        bus.showTitle    = t;
    endtask

    task automatic set_kind(input int kind);
        set_mode(kind == K_BLACK, kind == K_FLASH, kind == K_GO, kind == K_TITLE);
    endtask

    function automatic int exp_col(input int kind, input int addr);
        case (kind)
            K_BLACK: return 0;
            K_FLASH: return 4;
            K_GO:    return (~addr) & 7;
            default: return addr & 7;
        endcase
    endfunction

    task automatic drain();
        bus.wren = 1'b0;
        repeat (3) tick();
    endtask

    // Issue n_issue pixels from (0,0), switching mode at pixel switch_at, and check the stream
    task automatic stream(input int n_issue, input int switch_at, input int kind_a, input int kind_b,
                          output int plots, output int dones, output int done_at, output int bad);
        int p;
        int pa;
        plots = 0; dones = 0; done_at = -1; bad = 0;
        for (int i = 0; i < NPIX; i++) begin
            gx[i] = -1; gy[i] = -1; gc[i] = -1;
        end
        for (int k = 0; k < n_issue + 2; k++) begin
            if (k < n_issue) begin
                set_kind(k < switch_at ? kind_a : kind_b);
                bus.wren = 1'b1;
                if (int'(bus.rom_addr) != k % NPIX) bad++;
            end else begin
                bus.wren = 1'b0;
            end
            tick();
            p = k - 1;
            if (bus.plot === 1'b1) plots++;
            if (bus.frame_done === 1'b1) begin
                dones++;
                done_at = k + 1;
            end
            if (p >= 0 && p < n_issue) begin
                pa = p % NPIX;
                if (bus.plot !== 1'b1) bad++;
                if (int'(bus.colour) != exp_col(p < switch_at ? kind_a : kind_b, pa)) bad++;
                if (int'(bus.x) != pa % W || int'(bus.y) != pa / W) bad++;
                if ((bus.frame_done === 1'b1) != (pa == NPIX - 1)) bad++;
                gx[pa] = int'(bus.x);
                gy[pa] = int'(bus.y);
                gc[pa] = int'(bus.colour);
            end else if (bus.plot !== 1'b0 || bus.frame_done !== 1'b0) begin
                bad++;
            end
        end
    endtask

    initial begin
        int plots, dones, done_at, bad;

        vecs[0] = '{1, 0, 0, 0, 1, 0};
        vecs[1] = '{1, 1, 0, 0, 1, 0};
        vecs[2] = '{0, 1, 0, 0, 1, 4};
        vecs[3] = '{0, 1, 1, 0, 1, 4};
        vecs[4] = '{0, 0, 1, 0, 1, 2};
        vecs[5] = '{0, 0, 1, 1, 1, 2};
        vecs[6] = '{0, 0, 0, 1, 1, 5};
        vecs[7] = '{0, 0, 0, 0, 0, 0};
        vecs[8] = '{1, 1, 1, 1, 1, 0};

        // Reset held for two edges with painting requested
        rst = 1'b1;
        bus.wren = 1'b1;
        set_mode(1, 0, 0, 0);
        for (int i = 0; i < 2; i++) begin
            tick();
            chk("rst_plot", int'(bus.plot), 0);
            chk("rst_done", int'(bus.frame_done), 0);
            chk("rst_x", int'(bus.x), 0);
            chk("rst_y", int'(bus.y), 0);
            chk("rst_colour", int'(bus.colour), 0);
            chk("rst_rom_addr", int'(bus.rom_addr), 0);
        end
        rst = 1'b0;
        chk("rel_plot", int'(bus.plot), 0);
        chk("rel_rom_addr", int'(bus.rom_addr), 0);

        // Full black frame straight out of reset
        stream(NPIX, NPIX, K_BLACK, K_BLACK, plots, dones, done_at, bad);
        chk("black_stream_errs", bad, 0);
        chk("black_plots", plots, NPIX);
        chk("black_done_count", dones, 1);
        chk("black_done_cycle", done_at, NPIX + 1);
        chk("black_first_x", gx[0], 0);
        chk("black_first_y", gy[0], 0);
        chk("black_first_col", gc[0], 0);
        chk("black_wrap_x159", gx[159], 159);
        chk("black_wrap_y0", gy[159], 0);
        chk("black_wrap_x0", gx[160], 0);
        chk("black_wrap_y1", gy[160], 1);
        chk("black_last_x", gx[NPIX - 1], 159);
        chk("black_last_y", gy[NPIX - 1], 119);
        drain();

        // Title ROM alignment over two rows
        stream(330, 330, K_TITLE, K_TITLE, plots, dones, done_at, bad);
        chk("title_stream_errs", bad, 0);
        chk("title_plots", plots, 330);
        chk("title_dones", dones, 0);
        chk("title_5_1_x", gx[165], 5);
        chk("title_5_1_y", gy[165], 1);
        chk("title_5_1_col", gc[165], 5);
        drain();

        // Mode priority table: pixel (5,0) at ROM address 5
        foreach (vecs[i]) begin
            set_mode(vecs[i].black, vecs[i].flsh, vecs[i].go, vecs[i].title);
            bus.wren = 1'b1;
            repeat (7) tick();
            chk($sformatf("vec%0d_plot", i), int'(bus.plot), int'(vecs[i].exp_plot));
            chk($sformatf("vec%0d_done", i), int'(bus.frame_done), 0);
            if (vecs[i].exp_plot) begin
                chk($sformatf("vec%0d_colour", i), int'(bus.colour), vecs[i].exp_col);
                chk($sformatf("vec%0d_x", i), int'(bus.x), 5);
            end
            drain();
        end

        // Flash then switch to game-over at pixel 50 without counter restart
        stream(100, 50, K_FLASH, K_GO, plots, dones, done_at, bad);
        chk("flashgo_stream_errs", bad, 0);
        chk("flashgo_plots", plots, 100);
        chk("flashgo_p49_col", gc[49], 4);
        chk("flashgo_p50_col", gc[50], 5);
        chk("flashgo_p50_x", gx[50], 50);
        drain();

        // Early wren drop: 100 on, 3 off, then on again
        set_mode(1, 0, 0, 0);
        plots = 0;
        dones = 0;
        for (int k = 0; k < 106; k++) begin
            bus.wren = (k < 100 || k >= 103);
            if (k == 103) chk("drop_restart_addr", int'(bus.rom_addr), 0);
            tick();
            if (k + 1 <= 104 && bus.plot === 1'b1) plots++;
            if (bus.frame_done === 1'b1) dones++;
            if (k + 1 == 105) begin
                chk("drop_restart_plot", int'(bus.plot), 1);
                chk("drop_restart_x", int'(bus.x), 0);
                chk("drop_restart_y", int'(bus.y), 0);
            end
        end
        chk("drop_plots", plots, 100);
        chk("drop_dones", dones, 0);
        drain();

        // Reset mid-frame at pixel 500
        set_mode(1, 0, 0, 0);
        bus.wren = 1'b1;
        repeat (500) tick();
        chk("midrst_inflight_plot", int'(bus.plot), 1);
        chk("midrst_inflight_x", int'(bus.x), 498 % W);
        rst = 1'b1;
        tick();
        chk("midrst_plot_a", int'(bus.plot), 0);
        chk("midrst_done", int'(bus.frame_done), 0);
        rst = 1'b0;
        chk("midrst_addr", int'(bus.rom_addr), 0);
        tick();
        chk("midrst_plot_b", int'(bus.plot), 0);
        tick();
        chk("midrst_restart_plot", int'(bus.plot), 1);
        chk("midrst_restart_x", int'(bus.x), 0);
        chk("midrst_restart_y", int'(bus.y), 0);
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/splash_painter.md
Name: splash_painter

Overview:
- Pixel generator directly downstream of the splash/title FSM.
- Consumes the FSM's mode strobes (showTitle, drawBlack, showGameOver, flash) and its wren enable.
- Rasters a WIDTH x HEIGHT frame, fetches title or game-over pixels from synchronous ROMs, and drives x/y/colour/plot into the VGA framebuffer write port.
- Output is a fixed 2-cycle pipeline. It emits a frame_done pulse when the last pixel is written.

Parameters:
- WIDTH, 160, pixels per row; x counter range 0..WIDTH-1.
- HEIGHT, 120, rows per frame; y counter range 0..HEIGHT-1.
- FLASH_COLOUR, 3'b100, colour written in flash mode (red).

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- showTitle  in  1  paint title image from title ROM.
- drawBlack  in  1  paint solid black.
- showGameOver  in  1  paint game-over image from game-over ROM.
- flash  in  1  paint solid FLASH_COLOUR.
- wren  in  1  painting enable; one pixel is issued per cycle while high.
- title_pix  in  3  title ROM data, valid 1 cycle after rom_addr.
- gameover_pix  in  3  game-over ROM data, valid 1 cycle after rom_addr.
- rom_addr  out  15  shared ROM read address = y_cnt*WIDTH + x_cnt.
- x  out  8  framebuffer column.
- y  out  7  framebuffer row.
- colour  out  3  framebuffer pixel colour.
- plot  out  1  framebuffer write enable.
- frame_done  out  1  one-cycle pulse, coincident with the plot of pixel (WIDTH-1, HEIGHT-1).

Behaviour:
- Reset (rst=1 at an edge) clears:
  - x_cnt, y_cnt, and both pipeline valid bits;
  - x, y, colour, plot, frame_done, all to 0.
- rom_addr = 0 after reset.
- rst has priority over all other inputs. Reset mid-frame aborts the frame immediately; no further plot pulses are issued from in-flight pixels.
- Stage 0 (issue), on a cycle with wren=1:
  - the current (x_cnt, y_cnt) is issued;
  - rom_addr is driven combinationally from the counters;
  - mode is captured into stage-1 registers along with x_cnt, y_cnt and last = (x_cnt==WIDTH-1 && y_cnt==HEIGHT-1);
  - valid1 <= 1.
- Counter advance on each issue:
  - x_cnt++;
  - at x_cnt==WIDTH-1: x_cnt <= 0, y_cnt++;
  - at the last pixel: both wrap to 0, so a held wren repaints continuously.
- wren=0:
  - x_cnt and y_cnt clear to 0 on that edge; the next rising wren always starts at (0,0);
  - valid1 <= 0;
  - in-flight pixels still drain.
- Stage 1: the ROM registers rom_addr. Stage-1 registers advance to stage 2 unconditionally (no stalls).
- Stage 2 (output registers), on each edge:
  - plot <= valid1 && (mode != NONE);
  - x and y <= stage-1 coordinates;
  - frame_done <= valid1 && last && plot condition.
- Total latency from the issue cycle to the plot cycle is 2 clocks.
- Mode priority, with the encoding captured at issue: drawBlack > flash > showGameOver > showTitle > NONE.
- Colour selected at stage 2:
  - BLACK -> 3'b000;
  - FLASH -> FLASH_COLOUR;
  - GAMEOVER -> gameover_pix;
  - TITLE -> title_pix.
- NONE while wren=1: the counters still advance, but plot stays 0 and frame_done stays 0.
- Mode changing mid-frame: each pixel uses the mode sampled on its own issue cycle. The counters do not restart.
- Width rules:
  - rom_addr computed at 15 bits; maximum value is WIDTH*HEIGHT-1 = 19199;
  - x is zero-extended to 8 bits, y to 7 bits.
- Back-to-back frames: after the last pixel with wren still high, the next cycle issues (0,0). No bubble is inserted and frame_done pulses once per completed frame.

Test Plan:
- Reset: hold rst 2 cycles with wren=1, drawBlack=1 -> plot=0, frame_done=0, x=0, y=0, colour=0, rom_addr=0 throughout, and on the first cycle after release.
- Black frame: drawBlack=1, wren high for 19200 cycles from cycle 0 -> first plot at cycle 2 with (x,y)=(0,0), colour=0; row wrap observed as (159,0)->(0,1); frame_done exactly once, at cycle 19201, with (159,119).
- Title ROM alignment: showTitle=1, ROM model returns addr[2:0] one cycle late -> the pixel plotted at (x,y) carries colour (y*160+x)[2:0], e.g. (5,1) -> 3'b101.
- Priority and flash: assert drawBlack and flash together -> colour 0. Then flash=1 alone -> colour 3'b100. Switch to showGameOver at pixel 50 -> pixels 0..49 red, 50 onward gameover_pix, with no counter restart.
- Early wren drop: wren high 100 cycles, low 3, high again -> exactly 100 plots drain; the next issued pixel is (0,0); no frame_done.
- Reset mid-frame: rst=1 at pixel 500 with valid pixels in flight -> plot=0 from the next cycle; after release with wren=1, painting restarts at (0,0).
